// File: rtl/axis_pkt_checker_if.sv
// -----------------------------------------------------------------------------
// axis_pkt_checker_if
// Purpose : AXI-Stream bus bundle carrying packets into axis_pkt_checker.
// Signals : tdata  [DW-1:0]   stream data
//           tkeep  [DW/8-1:0] byte enables
//           tuser  [UW-1:0]   sideband metadata
//           tvalid            beat valid        (master -> slave)
//           tready            beat ready        (slave  -> master)
//           tlast             last beat of packet
// Modports: master drives the stream, slave consumes it and drives tready.
// -----------------------------------------------------------------------------
interface axis_pkt_checker_if #(
    parameter int DW = 512,
    parameter int UW = 128
);
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic [UW-1:0]   tuser;
    logic            tvalid;
    logic            tready;
    logic            tlast;

    modport master (
        output tdata,
        output tkeep,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_pkt_checker.sv
// -----------------------------------------------------------------------------
// axis_pkt_checker
// Purpose : AXI-Stream sink for the egress of the RMT pipeline. Throttles the
//           stream with LFSR-driven backpressure, checks each packet's beat
//           layout (keep rules, per-beat sequence numbers, maximum length) and
//           keeps packet / byte / error statistics.
// Ports   : clk            stream clock
//           areset         asynchronous reset, active-high
//           s_axis         slave AXI-Stream (tdata/tkeep/tuser/tvalid/tlast in,
//                          tready out, registered)
//           bp_level [3:0] backpressure level, 0 keeps tready high
//           clr            synchronous clear of counters and flags
//           pkt_done       one-cycle pulse after every accepted tlast beat
//           pkt_cnt  [31:0] completed packets (wraps)
//           byte_cnt [63:0] accepted bytes, popcount of tkeep (wraps)
//           err_cnt  [31:0] errored beats (saturates)
//           err_flags [2:0] sticky {len, data, keep}
//           first_err_data [63:0] tdata[63:0] of first errored beat since clr
// -----------------------------------------------------------------------------
module axis_pkt_checker #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 512,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          MAX_BEATS            = 64,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 areset,
    axis_pkt_checker_if.slave    s_axis,
    input  logic [3:0]           bp_level,
    input  logic                 clr,
    output logic                 pkt_done,
    output logic [31:0]          pkt_cnt,
    output logic [63:0]          byte_cnt,
    output logic [31:0]          err_cnt,
    output logic [2:0]           err_flags,
    output logic [63:0]          first_err_data
);
    localparam int DW  = C_S_AXIS_DATA_WIDTH;
    localparam int UW  = C_S_AXIS_TUSER_WIDTH;
    localparam int KW  = DW / 8;
    localparam int PCW = $clog2(KW) + 1;
    localparam int KBW = $clog2(MAX_BEATS) + 1;
    localparam logic [KBW-1:0] K_LAST   = KBW'(MAX_BEATS - 1);
    localparam logic [31:0]    ERR_MAX  = 32'hFFFF_FFFF;
    localparam logic [KW-1:0]  KEEP_ALL = {KW{1'b1}};
    localparam logic [KW-1:0]  KEEP_0   = {KW{1'b0}};

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_BASE = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // Number of set byte enables in a keep vector.
    function automatic logic [PCW-1:0] popcount(input logic [KW-1:0] v);
        logic [PCW-1:0] c;
        c = {PCW{1'b0}};
        for (int i = 0; i < KW; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    // True when v is non-zero and of the form 2^n-1: adding one to such a
    // value carries through every set bit, so the AND comes out zero.
    function automatic logic keep_is_prefix(input logic [KW-1:0] v);
        return (v != KEEP_0) && ((v & (v + KW'(1))) == KEEP_0);
    endfunction

    // ---------------- state ----------------
    state_t          state_q, state_d;
    logic [KBW-1:0]  k_q, k_d;
    logic [63:0]     base_q, base_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic            tready_q, tready_d;
    logic            pkt_done_q, pkt_done_d;
    logic [31:0]     pkt_cnt_q, pkt_cnt_d;
    logic [63:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]     err_cnt_q, err_cnt_d;
    logic [2:0]      err_flags_q, err_flags_d;
    logic [63:0]     first_err_q, first_err_d;

    // ---------------- combinational helpers ----------------
    logic            beat_acc_s;
    logic            keep_bad_s;
    logic            len_hit_s;
    logic            keep_viol_s;
    logic            data_viol_s;
    logic            len_viol_s;
    logic            beat_err_s;
    logic [63:0]     data_lo_s;
    logic [63:0]     expect_s;
    logic [PCW-1:0]  beat_bytes_s;
    logic            unused_bits_s;

    assign beat_acc_s   = s_axis.tvalid & tready_q;
    assign data_lo_s    = s_axis.tdata[63:0];
    // Beat k of a packet carries B + (k-1); modular 64-bit arithmetic.
    assign expect_s     = base_q + 64'(k_q) - 64'd1;
    // Reaching the last permitted beat index without tlast is a length error.
    assign len_hit_s    = (k_q == K_LAST) & ~s_axis.tlast;
    assign beat_bytes_s = popcount(s_axis.tkeep);
    assign beat_err_s   = beat_acc_s & (keep_viol_s | data_viol_s | len_viol_s);

    // Metadata and the upper data lanes are carried but never inspected.
    assign unused_bits_s = ^{s_axis.tuser, s_axis.tdata[DW-1:64]};

    // ---------------- backpressure ----------------
    // Fibonacci LFSR, taps 16,14,13,11; tready is decided one cycle ahead.
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign tready_d = (lfsr_q[3:0] >= bp_level);

    // LFSR and registered tready; neither is touched by clr.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            lfsr_q   <= LFSR_SEED;
            tready_q <= 1'b1;
        end else begin
            lfsr_q   <= lfsr_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis.tready = tready_q;

    // ---------------- packet FSM ----------------
    // FSM state register with beat index and captured base value.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_HDR;
            k_q     <= {KBW{1'b0}};
            base_q  <= 64'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
        end
    end

    // FSM next-state: advances only on accepted beats, regardless of clr.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        if (beat_acc_s) begin
            case (state_q)
                S_HDR: begin
                    if (s_axis.tlast) begin
                        state_d = S_HDR;
                        k_d     = {KBW{1'b0}};
                    end else begin
                        state_d = S_BASE;
                        k_d     = KBW'(1);
                    end
                end
                S_BASE: begin
                    base_d = data_lo_s;
                    if (s_axis.tlast) begin
                        state_d = S_HDR;
                        k_d     = {KBW{1'b0}};
                    end else begin
                        state_d = S_DATA;
                        k_d     = KBW'(2);
                    end
                end
                S_DATA: begin
                    if (s_axis.tlast) begin
                        state_d = S_HDR;
                        k_d     = {KBW{1'b0}};
                    end else if (len_hit_s) begin
                        state_d = S_DROP;
                        k_d     = k_q;
                    end else begin
                        state_d = S_DATA;
                        k_d     = k_q + KBW'(1);
                    end
                end
                S_DROP: begin
                    if (s_axis.tlast) begin
                        state_d = S_HDR;
                        k_d     = {KBW{1'b0}};
                    end else begin
                        state_d = S_DROP;
                        k_d     = k_q;
                    end
                end
                default: begin
                    state_d = S_HDR;
                    k_d     = {KBW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Keep rule: non-last beats full, last beat a non-empty prefix.
    always_comb begin
        if (s_axis.tlast) begin
            keep_bad_s = ~keep_is_prefix(s_axis.tkeep);
        end else begin
            keep_bad_s = (s_axis.tkeep != KEEP_ALL);
        end
    end

    // FSM outputs: which rules apply to the beat presented in this state.
    always_comb begin
        keep_viol_s = 1'b0;
        data_viol_s = 1'b0;
        len_viol_s  = 1'b0;
        case (state_q)
            S_HDR, S_BASE: begin
                keep_viol_s = keep_bad_s;
            end
            S_DATA: begin
                keep_viol_s = keep_bad_s;
                data_viol_s = (data_lo_s != expect_s);
                len_viol_s  = len_hit_s;
            end
            S_DROP: begin
                keep_viol_s = 1'b0;
            end
            default: begin
                keep_viol_s = 1'b0;
            end
        endcase
    end

    // ---------------- statistics ----------------
    // Statistics next-state; clr wins over a beat accepted in the same cycle.
    always_comb begin
        pkt_done_d  = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_cnt_d   = err_cnt_q;
        err_flags_d = err_flags_q;
        first_err_d = first_err_q;
        if (clr) begin
            pkt_cnt_d   = 32'd0;
            byte_cnt_d  = 64'd0;
            err_cnt_d   = 32'd0;
            err_flags_d = 3'b000;
            first_err_d = 64'd0;
        end else if (beat_acc_s) begin
            pkt_done_d = s_axis.tlast;
            byte_cnt_d = byte_cnt_q + 64'(beat_bytes_s);
            if (s_axis.tlast) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
            if (beat_err_s) begin
                err_flags_d = err_flags_q | {len_viol_s, data_viol_s, keep_viol_s};
                // Every errored beat increments err_cnt, so zero means
                // this is the first one since the last clear.
                if (err_cnt_q == 32'd0) begin
                    first_err_d = data_lo_s;
                end else begin
                    first_err_d = first_err_q;
                end
                if (err_cnt_q != ERR_MAX) begin
                    err_cnt_d = err_cnt_q + 32'd1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            pkt_done_d = 1'b0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pkt_done_q  <= 1'b0;
            pkt_cnt_q   <= 32'd0;
            byte_cnt_q  <= 64'd0;
            err_cnt_q   <= 32'd0;
            err_flags_q <= 3'b000;
            first_err_q <= 64'd0;
        end else begin
            pkt_done_q  <= pkt_done_d;
            pkt_cnt_q   <= pkt_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_cnt_q   <= err_cnt_d;
            err_flags_q <= err_flags_d;
            first_err_q <= first_err_d;
        end
    end

    assign pkt_done       = pkt_done_q;
    assign pkt_cnt        = pkt_cnt_q;
    assign byte_cnt       = byte_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign err_flags      = err_flags_q;
    assign first_err_data = first_err_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_checker
// Randomized stimulus for axis_pkt_checker with a packet-level reference
// model of the layout rules and the backpressure sequence.
// -----------------------------------------------------------------------------
module tb_axis_pkt_checker;
    localparam int          DW       = 512;
    localparam int          UW       = 128;
    localparam int          KW       = DW / 8;
    localparam int          MAXB     = 4;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [KW-1:0] KEEP_ALL = {KW{1'b1}};

    logic        clk;
    logic        areset;
    logic [3:0]  bp_level;
    logic        clr;
    logic        pkt_done;
    logic [31:0] pkt_cnt;
    logic [63:0] byte_cnt;
    logic [31:0] err_cnt;
    logic [2:0]  err_flags;
    logic [63:0] first_err_data;

    axis_pkt_checker_if #(.DW(DW), .UW(UW)) s_axis ();

    axis_pkt_checker #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .MAX_BEATS            (MAXB),
        .LFSR_SEED            (SEED)
    ) dut (
        .clk            (clk),
        .areset         (areset),
        .s_axis         (s_axis),
        .bp_level       (bp_level),
        .clr            (clr),
        .pkt_done       (pkt_done),
        .pkt_cnt        (pkt_cnt),
        .byte_cnt       (byte_cnt),
        .err_cnt        (err_cnt),
        .err_flags      (err_flags),
        .first_err_data (first_err_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pkt;
    logic [63:0] m_bytes;
    logic [31:0] m_err;
    logic [2:0]  m_flags;
    logic [63:0] m_first;
    int          m_done = 0;
    int          w_k;
    logic [63:0] w_base;
    bit          w_drop;

    function automatic void model_clear();
        m_pkt   = 32'd0;
        m_bytes = 64'd0;
        m_err   = 32'd0;
        m_flags = 3'b000;
        m_first = 64'd0;
    endfunction

    // Apply the layout rules to one accepted beat at packet position w_k.
    function automatic void model_beat(input logic [63:0] d, input logic [KW-1:0] keep,
                                       input bit last, input bit counted);
        bit kerr, derr, lerr;
        int n;
        kerr = 1'b0; derr = 1'b0; lerr = 1'b0;
        n = $countones(keep);
        if (!w_drop) begin
            if (last) kerr = (n == 0) || (keep != (KEEP_ALL >> (KW - n)));
            else      kerr = (keep != KEEP_ALL);
            if (w_k == 1) w_base = d;
            if (w_k >= 2) derr = (d != w_base + 64'(w_k - 1));
            if (w_k == MAXB - 1 && !last) lerr = 1'b1;
        end
        if (counted) begin
            m_bytes = m_bytes + 64'(n);
            if (last) begin
                m_pkt = m_pkt + 32'd1;
                m_done++;
            end
            if (kerr || derr || lerr) begin
                if (m_err == 32'd0) m_first = d;
                if (m_err != 32'hFFFF_FFFF) m_err = m_err + 32'd1;
                m_flags = m_flags | {lerr, derr, kerr};
            end
        end
        if (last) begin
            w_k = 0;
            w_drop = 1'b0;
        end else begin
            w_k++;
            if (lerr) w_drop = 1'b1;
        end
    endfunction

    // Backpressure reference: tready for the next cycle from the current LFSR.
    logic [15:0] m_lfsr;
    logic        exp_rdy;
    bit          started = 1'b0;
    always @(posedge clk or posedge areset) begin
        if (areset) begin
            m_lfsr  <= SEED;
            exp_rdy <= 1'b1;
        end else begin
            exp_rdy <= (m_lfsr[3:0] >= bp_level);
            m_lfsr  <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    int dn_seen = 0;
    int rdy_lo  = 0;
    always @(negedge clk) begin
        if (pkt_done === 1'b1) dn_seen++;
        if (s_axis.tready !== 1'b1) rdy_lo++;
        if (started && !areset) chk("tready", s_axis.tready, exp_rdy);
    end

    // ---------------- driver ----------------
    logic [63:0]   qd[$];
    logic [KW-1:0] qk[$];

    // Called just after a negedge; returns just after the following negedge.
    task automatic send_beat(input logic [63:0] d, input logic [KW-1:0] keep,
                             input bit last, input bit with_clr);
        int waited;
        waited = 0;
        s_axis.tdata[63:0] = d;
        for (int i = 2; i < DW / 32; i++) s_axis.tdata[i*32 +: 32] = $urandom;
        s_axis.tkeep  = keep;
        s_axis.tlast  = last;
        s_axis.tuser  = UW'($urandom);
        s_axis.tvalid = 1'b1;
        while (s_axis.tready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            chk("tready_wait", s_axis.tready, 1'b1);
        end else begin
            clr = with_clr;
            @(posedge clk);
            if (with_clr) model_clear();
            model_beat(d, keep, last, !with_clr);
        end
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        clr           = 1'b0;
    endtask

    task automatic send_pkt(input bit gaps);
        for (int i = 0; i < qd.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(qd[i], qk[i], (i == qd.size() - 1), 1'b0);
        end
    endtask

    function automatic logic [KW-1:0] keep_n(input int n);
        return KEEP_ALL >> (KW - n);
    endfunction

    // Header, base, base+1, ... with full keep except the last beat.
    function automatic void build_clean(input int nb, input logic [63:0] base, input int last_bytes);
        qd.delete();
        qk.delete();
        for (int i = 0; i < nb; i++) begin
            if (i == 0) qd.push_back({$urandom, $urandom});
            else        qd.push_back(base + 64'(i - 1));
            qk.push_back(KEEP_ALL);
        end
        qk[nb-1] = keep_n(last_bytes);
    endfunction

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, ".pkt_cnt"},   pkt_cnt,        m_pkt);
        chk({tag, ".byte_cnt"},  byte_cnt,       m_bytes);
        chk({tag, ".err_cnt"},   err_cnt,        m_err);
        chk({tag, ".err_flags"}, err_flags,      m_flags);
        chk({tag, ".first_err"}, first_err_data, m_first);
        chk({tag, ".pulses"},    dn_seen,        m_done);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lo0;
        areset        = 1'b1;
        clr           = 1'b0;
        bp_level      = 4'd0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tuser  = '0;
        model_clear();
        w_k = 0; w_drop = 1'b0; w_base = 64'd0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst.tready",    s_axis.tready,  1'b1);
        chk("rst.pkt_done",  pkt_done,       1'b0);
        chk("rst.pkt_cnt",   pkt_cnt,        32'd0);
        chk("rst.byte_cnt",  byte_cnt,       64'd0);
        chk("rst.err_cnt",   err_cnt,        32'd0);
        chk("rst.err_flags", err_flags,      3'b000);
        chk("rst.first_err", first_err_data, 64'd0);
        areset  = 1'b0;
        started = 1'b1;
        @(negedge clk);

        // 1: four clean 3-beat packets, no backpressure
        for (int p = 0; p < 4; p++) begin
            build_clean(3, 64'd5, 64);
            send_pkt(1'b0);
        end
        check_status("t1");
        chk("t1.byte_lit", byte_cnt, 64'd768);
        chk("t1.pulse_lit", dn_seen, 4);

        // 2: sequence error then a clean packet
        pulse_clr();
        build_clean(3, 64'd5, 64);
        qd[2] = 64'd7;
        send_pkt(1'b0);
        check_status("t2a");
        chk("t2.flags_lit", err_flags, 3'b010);
        chk("t2.first_lit", first_err_data, 64'd7);
        build_clean(3, 64'd5, 64);
        send_pkt(1'b0);
        check_status("t2b");

        // 3: keep rules
        pulse_clr();
        build_clean(3, 64'd20, 6);
        send_pkt(1'b0);
        check_status("t3a");
        chk("t3a.byte_lit", byte_cnt, 64'd134);
        build_clean(3, 64'd30, 0);
        send_pkt(1'b0);
        check_status("t3b");
        chk("t3b.flags_lit", err_flags, 3'b001);
        pulse_clr();
        build_clean(3, 64'd40, 64);
        qk[2] = 64'h5;
        send_pkt(1'b0);
        check_status("t3c");
        pulse_clr();
        build_clean(3, 64'd50, 64);
        qk[1] = 64'hFFFF;
        send_pkt(1'b0);
        check_status("t3d");

        // 4: over-length packet then a normal one
        pulse_clr();
        build_clean(6, 64'd10, 64);
        send_pkt(1'b0);
        check_status("t4a");
        chk("t4.flags_lit", err_flags, 3'b100);
        chk("t4.bytes_lit", byte_cnt, 64'd384);
        chk("t4.first_lit", first_err_data, 64'd12);
        build_clean(3, 64'd77, 64);
        send_pkt(1'b0);
        check_status("t4b");

        // 6a: clr coincident with beat 1
        pulse_clr();
        send_beat(64'hDEAD, KEEP_ALL, 1'b0, 1'b0);
        send_beat(64'd300, KEEP_ALL, 1'b0, 1'b1);
        chk("t6a.clr_pkt_done", pkt_done, 1'b0);
        chk("t6a.clr_bytes",    byte_cnt, 64'd0);
        send_beat(64'd301, KEEP_ALL, 1'b1, 1'b0);
        check_status("t6a");

        // 6b: areset after a header beat
        send_beat(64'hBEEF, KEEP_ALL, 1'b0, 1'b0);
        areset = 1'b1;
        model_clear();
        w_k = 0; w_drop = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        build_clean(3, 64'd500, 64);
        send_pkt(1'b0);
        check_status("t6b");

        // 5: random traffic under backpressure
        pulse_clr();
        bp_level = 4'd8;
        lo0 = rdy_lo;
        for (int p = 0; p < 200; p++) begin
            build_clean($urandom_range(1, 3),
                        (p == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom},
                        $urandom_range(1, 64));
            send_pkt(1'b1);
        end
        check_status("t5");
        chk("t5.pkt_lit", pkt_cnt, 32'd200);
        chk("t5.err_lit", err_cnt, 32'd0);
        chk("t5.tready_low_seen", (rdy_lo > lo0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
